// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
// Module      : key_entry
// Description : Assembles keypad key events into a BCD entry buffer and
//               converts it to binary on enter with a multiply-by-10 loop.
// Revision    : 1.0 - initial release
// ============================================================================
module key_entry #(
    parameter int         DIGITS      = 4,
    parameter int         VALUE_W     = 14,
    parameter logic       TRIG_ACTIVE = 1'b1,
    parameter logic [3:0] KEY_BS      = 4'hA,
    parameter logic [3:0] KEY_CLR     = 4'hB,
    parameter logic [3:0] KEY_ENT     = 4'hC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            keycode_i,
    input  logic                  keytrig_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [2:0]            digit_cnt_o,
    output logic [VALUE_W-1:0]    value_o,
    output logic                  value_valid_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int         c_BCD_W      = 4 * DIGITS;
    localparam logic [2:0] c_DIGITS_CNT = 3'(DIGITS);
    localparam logic [2:0] c_LAST_STEP  = 3'(DIGITS - 1);

    localparam logic [0:0] c_ST_ENTRY = 1'b0;
    localparam logic [0:0] c_ST_CONV  = 1'b1;

    logic [0:0]          r_state;
    logic                r_trig_prev;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [2:0]          r_cnt;
    logic [c_BCD_W-1:0]  r_shreg;
    logic [VALUE_W-1:0]  r_acc;
    logic [2:0]          r_step;
    logic [VALUE_W-1:0]  r_value;
    logic                r_valid;
    logic                r_busy;
    logic                r_err;

    logic [0:0]          w_state;
    logic [c_BCD_W-1:0]  w_bcd;
    logic [2:0]          w_cnt;
    logic [c_BCD_W-1:0]  w_shreg;
    logic [VALUE_W-1:0]  w_acc;
    logic [2:0]          w_step;
    logic [VALUE_W-1:0]  w_value;
    logic                w_valid;
    logic                w_busy;
    logic                w_err;
    logic                w_key_event;
    logic [VALUE_W-1:0]  w_acc_calc;

    // One event per trigger pulse: active level now, idle level last cycle.
    assign w_key_event = (keytrig_i == TRIG_ACTIVE) && (r_trig_prev == ~TRIG_ACTIVE);

    // acc*10 built from shifts so no multiplier is inferred.
    assign w_acc_calc = (r_acc << 3) + (r_acc << 1) + VALUE_W'(r_shreg[c_BCD_W-1 -: 4]);

    always_comb begin
        w_state = r_state;
        w_bcd   = r_bcd;
        w_cnt   = r_cnt;
        w_shreg = r_shreg;
        w_acc   = r_acc;
        w_step  = r_step;
        w_value = r_value;
        w_valid = 1'b0;
        w_busy  = r_busy;
        w_err   = 1'b0;

        case (r_state)
            c_ST_ENTRY: begin
                if (w_key_event) begin
                    case (keycode_i)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                            if (r_cnt < c_DIGITS_CNT) begin
                                w_bcd = (r_bcd << 4) | c_BCD_W'(keycode_i);
                                w_cnt = r_cnt + 3'd1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        KEY_BS: begin
                            if (r_cnt != 3'd0) begin
                                w_bcd = r_bcd >> 4;
                                w_cnt = r_cnt - 3'd1;
                            end
                        end
                        KEY_CLR: begin
                            w_bcd = '0;
                            w_cnt = 3'd0;
                        end
                        KEY_ENT: begin
                            if (r_cnt != 3'd0) begin
                                w_shreg = r_bcd;
                                w_acc   = '0;
                                w_step  = 3'd0;
                                w_busy  = 1'b1;
                                w_bcd   = '0;
                                w_cnt   = 3'd0;
                                w_state = c_ST_CONV;
                            end
                        end
                        default: begin
                            // Unused codes (and unknown values) are ignored.
                        end
                    endcase
                end
            end
            c_ST_CONV: begin
                // Fixed latency: every digit, leading zeros included, takes a cycle.
                w_acc   = w_acc_calc;
                w_shreg = r_shreg << 4;
                w_step  = r_step + 3'd1;
                if (r_step == c_LAST_STEP) begin
                    w_value = w_acc_calc;
                    w_valid = 1'b1;
                    w_busy  = 1'b0;
                    w_state = c_ST_ENTRY;
                end
            end
            default: begin
                w_state = c_ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_ENTRY;
            r_trig_prev <= ~TRIG_ACTIVE;
            r_bcd       <= '0;
            r_cnt       <= 3'd0;
            r_shreg     <= '0;
            r_acc       <= '0;
            r_step      <= 3'd0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_trig_prev <= keytrig_i;
            r_bcd       <= w_bcd;
            r_cnt       <= w_cnt;
            r_shreg     <= w_shreg;
            r_acc       <= w_acc;
            r_step      <= w_step;
            r_value     <= w_value;
            r_valid     <= w_valid;
            r_busy      <= w_busy;
            r_err       <= w_err;
        end
    end

    assign bcd_o         = r_bcd;
    assign digit_cnt_o   = r_cnt;
    assign value_o       = r_value;
    assign value_valid_o = r_valid;
    assign busy_o        = r_busy;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_entry
// Description : Directed self-checking bench for key_entry with a value scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_entry;

    localparam int DIGITS  = 4;
    localparam int VALUE_W = 14;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           keycode = 4'h0;
    logic                 keytrig = 1'b0;
    logic [4*DIGITS-1:0]  bcd_o;
    logic [2:0]           digit_cnt_o;
    logic [VALUE_W-1:0]   value_o;
    logic                 value_valid_o;
    logic                 busy_o;
    logic                 err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_cyc = 0;
    int n_valid_cyc = 0;
    logic [VALUE_W-1:0] exp_q[$];

    key_entry #(
        .DIGITS      (DIGITS),
        .VALUE_W     (VALUE_W),
        .TRIG_ACTIVE (1'b1),
        .KEY_BS      (4'hA),
        .KEY_CLR     (4'hB),
        .KEY_ENT     (4'hC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .keycode_i     (keycode),
        .keytrig_i     (keytrig),
        .bcd_o         (bcd_o),
        .digit_cnt_o   (digit_cnt_o),
        .value_o       (value_o),
        .value_valid_o (value_valid_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each value_valid_o cycle pops one expected value.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (err_o) n_err_cyc++;
            if (value_valid_o) begin
                n_valid_cyc++;
                check("valid_without_err", 32'(err_o), 32'd0);
                if (exp_q.size() > 0) begin
                    check("sb_value", 32'(value_o), 32'(exp_q.pop_front()));
                end else begin
                    check("sb_unexpected_valid", 32'(exp_q.size()), 32'd1);
                end
            end
        end
    end

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        keycode = code;
        keytrig = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        keytrig = 1'b0;
        keycode = 4'hx;
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_expect(input logic [VALUE_W-1:0] v);
        exp_q.push_back(v);
        @(negedge clk);
        keycode = 4'hC;
        keytrig = 1'b1;
        @(posedge clk);
        #1;
        check("enter_busy", 32'(busy_o), 32'd1);
        check("enter_bcd_clr", 32'(bcd_o), 32'd0);
        check("enter_cnt_clr", 32'(digit_cnt_o), 32'd0);
        repeat (DIGITS - 1) begin
            @(posedge clk);
            #1;
            check("conv_no_valid", 32'(value_valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        check("valid_at_latency", 32'(value_valid_o), 32'd1);
        check("busy_done", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(value_valid_o), 32'd0);
        @(negedge clk);
        keytrig = 1'b0;
        keycode = 4'hx;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e0;
        int v0;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd_o), 32'd0);
        check("rst_cnt", 32'(digit_cnt_o), 32'd0);
        check("rst_value", 32'(value_o), 32'd0);
        check("rst_valid", 32'(value_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1,2,3,4 then enter
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("t1_bcd", 32'(bcd_o), 32'h1234);
        check("t1_cnt", 32'(digit_cnt_o), 32'd4);
        enter_expect(14'd1234);
        check("t1_value", 32'(value_o), 32'd1234);
        check("t1_bcd_after", 32'(bcd_o), 32'd0);

        // Overflow digit rejected
        press(4'h9); press(4'h9); press(4'h9); press(4'h9);
        e0 = n_err_cyc;
        press(4'h5);
        check("t2_err_pulses", 32'(n_err_cyc - e0), 32'd1);
        check("t2_bcd", 32'(bcd_o), 32'h9999);
        check("t2_cnt", 32'(digit_cnt_o), 32'd4);
        enter_expect(14'd9999);
        check("t2_value", 32'(value_o), 32'd9999);

        // Backspace
        press(4'h7); press(4'h8);
        check("t3_bcd_78", 32'(bcd_o), 32'h78);
        press(4'hA);
        check("t3_bcd_7", 32'(bcd_o), 32'h7);
        check("t3_cnt_1", 32'(digit_cnt_o), 32'd1);
        press(4'h3);
        check("t3_bcd_73", 32'(bcd_o), 32'h73);
        enter_expect(14'd73);
        press(4'hA);
        check("t3_bs_empty_bcd", 32'(bcd_o), 32'd0);
        check("t3_bs_empty_cnt", 32'(digit_cnt_o), 32'd0);

        // Clear, then enter on empty buffer is ignored
        v0 = n_valid_cyc;
        e0 = n_err_cyc;
        press(4'h5);
        press(4'hB);
        check("t4_bcd_clr", 32'(bcd_o), 32'd0);
        check("t4_cnt_clr", 32'(digit_cnt_o), 32'd0);
        press(4'hC);
        press(4'hD);
        repeat (DIGITS + 2) @(negedge clk);
        check("t4_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        check("t4_no_err", 32'(n_err_cyc - e0), 32'd0);
        check("t4_value_kept", 32'(value_o), 32'd73);
        check("t4_cnt_after_d", 32'(digit_cnt_o), 32'd0);

        // Key during conversion is dropped
        press(4'h4);
        exp_q.push_back(14'd4);
        e0 = n_err_cyc;
        @(negedge clk); keycode = 4'hC; keytrig = 1'b1;
        @(posedge clk);
        @(negedge clk); keytrig = 1'b0; keycode = 4'hx;
        @(posedge clk);
        @(negedge clk); keycode = 4'h6; keytrig = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy", 32'(busy_o), 32'd1);
        check("t5_bcd_conv", 32'(bcd_o), 32'd0);
        @(negedge clk); keytrig = 1'b0; keycode = 4'hx;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (value_valid_o) seen++;
        end
        check("t5_valid_count", 32'(seen), 32'd1);
        check("t5_value", 32'(value_o), 32'd4);
        check("t5_cnt", 32'(digit_cnt_o), 32'd0);
        check("t5_bcd", 32'(bcd_o), 32'd0);
        check("t5_no_err", 32'(n_err_cyc - e0), 32'd0);

        // Reset in the second conversion cycle
        press(4'h3);
        @(negedge clk); keycode = 4'hC; keytrig = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0; keytrig = 1'b0; keycode = 4'hx;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_value", 32'(value_o), 32'd0);
        check("t6_cnt", 32'(digit_cnt_o), 32'd0);
        v0 = n_valid_cyc;
        repeat (DIGITS + 3) @(negedge clk);
        check("t6_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        press(4'h2); press(4'h1);
        check("t6_bcd_21", 32'(bcd_o), 32'h21);
        enter_expect(14'd21);
        check("t6_value_21", 32'(value_o), 32'd21);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_entry.md
Name: key_entry

Overview:
- Consumes the 4x4 keypad scanner's keycode/trigger pair and assembles key presses into a multi-digit decimal number.
- Maintains a BCD entry buffer for display. Handles backspace, clear and enter. On enter, converts the buffer to binary with an iterative multiply-by-10 accumulator.
- Sits between the keypad scanner and the parameter registers / display driver of the measurement front end.

Parameters:
- DIGITS, 4, max number of decimal digits held in the entry buffer (1..6).
- VALUE_W, 14, width of the binary result; must satisfy 2^VALUE_W > 10^DIGITS-1.
- TRIG_ACTIVE, 1'b1, active level of keytrig_i; idle level is ~TRIG_ACTIVE.
- KEY_BS, 4'hA, keycode for backspace.
- KEY_CLR, 4'hB, keycode for clear.
- KEY_ENT, 4'hC, keycode for enter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- keycode_i  in  4  scanner keycode; may be X while no key is down; sampled only on a trigger edge
- keytrig_i  in  1  scanner trigger pulse; multi-cycle (typically 5 cycles)
- bcd_o  out  4*DIGITS  entry buffer; least-significant digit in [3:0]
- digit_cnt_o  out  3  number of digits currently held (0..DIGITS)
- value_o  out  VALUE_W  last converted binary value; held until the next conversion completes
- value_valid_o  out  1  one-cycle pulse when value_o updates
- busy_o  out  1  high while converting
- err_o  out  1  one-cycle pulse on a rejected digit (buffer full)

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous): all outputs 0, state ENTRY, trigger history register = ~TRIG_ACTIVE. Applies from any state, including mid-CONV; a partial conversion is discarded and value_o returns to 0.
- Key event:
  - Occurs at an edge where keytrig_i==TRIG_ACTIVE and the registered previous sample == ~TRIG_ACTIVE. keycode_i is sampled at that same edge, and the action's outputs update at that edge.
  - The history register updates every cycle in every state, so a held pulse produces exactly one event.
- State ENTRY, action per sampled code:
  - 0..9: if digit_cnt_o<DIGITS, bcd_o <= {bcd_o[4*DIGITS-5:0], code} and digit_cnt_o+1. Otherwise no change and err_o=1 for one cycle.
  - KEY_BS: if digit_cnt_o>0, bcd_o <= bcd_o>>4 and digit_cnt_o-1. Otherwise no-op.
  - KEY_CLR: bcd_o<=0, digit_cnt_o<=0.
  - KEY_ENT with digit_cnt_o>0: load the shift register with bcd_o, acc<=0, step<=0, busy_o<=1, then clear bcd_o and digit_cnt_o and enter CONV.
  - KEY_ENT with digit_cnt_o==0: ignored.
  - 0xD..0xF: ignored.
- State CONV:
  - Runs exactly DIGITS cycles, one digit per cycle. Each cycle: acc <= acc*10 + shreg top digit, where acc*10 = (acc<<3)+(acc<<1), truncated to VALUE_W. The shift register then shifts left 4; step+1.
  - Leading zeros are processed normally, so latency is fixed.
  - On the edge where step==DIGITS-1: value_o <= final acc, value_valid_o<=1 for one cycle, busy_o<=0, state ENTRY.
  - For enter event at edge E, value_valid_o is high in the cycle after edge E+DIGITS.
  - Key events arriving in CONV are dropped: no buffer change, no err_o.
- Simultaneous cases:
  - A key event cannot coincide with a buffer action other than the one it triggers.
  - A digit arriving on the edge where CONV completes is dropped.
  - err_o and value_valid_o are never both set.
- X keycode at a non-event edge has no effect. At an event edge, a value outside 0..F is treated as ignored.

Test Plan:
- Reset, then keys 1,2,3,4 then KEY_ENT (pulses 5 cycles each, TRIG_ACTIVE=1) -> bcd_o=16'h1234, digit_cnt_o=4 before enter; value_valid_o pulse 4 cycles after the enter edge with value_o=1234; bcd_o=0 afterwards.
- Keys 9,9,9,9,5 -> fifth key gives err_o one-cycle pulse, bcd_o stays 16'h9999; enter -> value_o=9999.
- Keys 7,8,KEY_BS,3,KEY_ENT -> bcd_o 0x78 then 0x7 then 0x73; value_o=73. Also: KEY_BS at digit_cnt_o=0 -> no change.
- Keys 5,KEY_CLR,KEY_ENT -> buffer cleared; enter ignored, no value_valid_o, value_o keeps its previous value.
- Key 4, enter, then key 6 triggered during CONV -> busy_o=1 during CONV; 6 dropped; value_o=4; digit_cnt_o=0 after completion.
- rst_n low for one edge in the second CONV cycle -> busy_o=0, value_o=0, no value_valid_o; a subsequent entry of 2,1 and enter gives value_o=21.
